// File: rtl/iq_demod_accumulator_if.sv
// Bus bundle for the I/Q demodulating accumulator: control, sample/LUT inputs
// and the integrated I/Q results.
interface iq_demod_accumulator_if #(
  parameter int S_WIDTH = 12,
  parameter int D_WIDTH = 12,
  parameter int N_LOG2  = 10
);
  localparam int ACC_WIDTH = S_WIDTH + D_WIDTH + N_LOG2;

  logic                        i_en;
  logic                        i_start;
  logic                        i_continuous;
  logic signed [S_WIDTH-1:0]   i_sample;
  logic                        i_sample_valid;
  logic signed [D_WIDTH-1:0]   i_sin;
  logic signed [D_WIDTH-1:0]   i_cos;
  logic signed [ACC_WIDTH-1:0] o_i;
  logic signed [ACC_WIDTH-1:0] o_q;
  logic                        o_valid;
  logic                        o_busy;

  modport master (
    output i_en, i_start, i_continuous, i_sample, i_sample_valid, i_sin, i_cos,
    input  o_i, o_q, o_valid, o_busy
  );

  modport slave (
    input  i_en, i_start, i_continuous, i_sample, i_sample_valid, i_sin, i_cos,
    output o_i, o_q, o_valid, o_busy
  );
endinterface

// File: rtl/iq_demod_accumulator.sv
// Lock-in style I/Q demodulator: aligns samples with LUT sin/cos, multiplies,
// and integrates over windows of 2^N_LOG2 valid samples.
module iq_demod_accumulator #(
  parameter int S_WIDTH     = 12,
  parameter int D_WIDTH     = 12,
  parameter int N_LOG2      = 10,
  parameter int LUT_LATENCY = 2
) (
  input logic                    i_clk,
  input logic                    i_rst,
  iq_demod_accumulator_if.slave  bus
);
  localparam int P_WIDTH   = S_WIDTH + D_WIDTH;
  localparam int ACC_WIDTH = P_WIDTH + N_LOG2;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e              state_q, state_d;
  logic [N_LOG2-1:0]   cnt_q, cnt_d;

  // Delay line: aligns each sample and its window tags with the LUT output
  logic signed [S_WIDTH-1:0] samp_dl_q [LUT_LATENCY];
  logic [LUT_LATENCY-1:0]    tag_dl_q, first_dl_q, last_dl_q;

  // Multiply stage
  logic signed [P_WIDTH-1:0] prod_i_q, prod_q_q;
  logic                      m_vld_q, m_first_q, m_last_q;

  // Accumulate / output stage
  logic signed [ACC_WIDTH-1:0] acc_i_q, acc_q_q, acc_i_d, acc_q_d;
  logic signed [ACC_WIDTH-1:0] o_i_q, o_q_q;
  logic                        o_valid_q;

  logic tag_in, first_in, last_in, drain_done;
  logic signed [P_WIDTH-1:0]   s_ext, cos_ext, sin_ext;
  logic signed [ACC_WIDTH-1:0] ext_i, ext_q;

  // Input-side window tagging and sign extension of operands
  always_comb begin
    tag_in   = (state_q == StAccum) && bus.i_sample_valid;
    first_in = tag_in && (cnt_q == '0);
    last_in  = tag_in && (cnt_q == '1);
    // A newer window's last sample still in the delay line means this strobe
    // belongs to an older window; keep draining.
    drain_done = m_vld_q && m_last_q && !(|last_dl_q);
    s_ext   = {{D_WIDTH{samp_dl_q[LUT_LATENCY-1][S_WIDTH-1]}}, samp_dl_q[LUT_LATENCY-1]};
    cos_ext = {{S_WIDTH{bus.i_cos[D_WIDTH-1]}}, bus.i_cos};
    sin_ext = {{S_WIDTH{bus.i_sin[D_WIDTH-1]}}, bus.i_sin};
    ext_i   = {{N_LOG2{prod_i_q[P_WIDTH-1]}}, prod_i_q};
    ext_q   = {{N_LOG2{prod_q_q[P_WIDTH-1]}}, prod_q_q};
    acc_i_d = m_first_q ? ext_i : acc_i_q + ext_i;
    acc_q_d = m_first_q ? ext_q : acc_q_q + ext_q;
  end

  // FSM next-state and sample counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          state_d = StAccum;
          cnt_d   = '0;
        end
      end
      StAccum: begin
        if (tag_in) begin
          cnt_d = cnt_q + 1'b1;  // wraps to 0 at window end
          if (last_in && !bus.i_continuous) state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register and counter, frozen while disabled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (bus.i_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Alignment delay line for sample and tags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < LUT_LATENCY; k++) samp_dl_q[k] <= '0;
      tag_dl_q   <= '0;
      first_dl_q <= '0;
      last_dl_q  <= '0;
    end else if (bus.i_en) begin
      samp_dl_q[0]  <= bus.i_sample;
      tag_dl_q[0]   <= tag_in;
      first_dl_q[0] <= first_in;
      last_dl_q[0]  <= last_in;
      for (int k = 1; k < LUT_LATENCY; k++) begin
        samp_dl_q[k]  <= samp_dl_q[k-1];
        tag_dl_q[k]   <= tag_dl_q[k-1];
        first_dl_q[k] <= first_dl_q[k-1];
        last_dl_q[k]  <= last_dl_q[k-1];
      end
    end
  end

  // Multiply stage: full-precision signed products
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prod_i_q  <= '0;
      prod_q_q  <= '0;
      m_vld_q   <= 1'b0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (bus.i_en) begin
      prod_i_q  <= s_ext * cos_ext;
      prod_q_q  <= s_ext * sin_ext;
      m_vld_q   <= tag_dl_q[LUT_LATENCY-1];
      m_first_q <= first_dl_q[LUT_LATENCY-1];
      m_last_q  <= last_dl_q[LUT_LATENCY-1];
    end
  end

  // Accumulate; final sum goes straight to the outputs on the same edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      o_i_q     <= '0;
      o_q_q     <= '0;
      o_valid_q <= 1'b0;
    end else begin
      o_valid_q <= 1'b0;
      if (bus.i_en && m_vld_q) begin
        acc_i_q <= acc_i_d;
        acc_q_q <= acc_q_d;
        if (m_last_q) begin
          o_i_q     <= acc_i_d;
          o_q_q     <= acc_q_d;
          o_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.o_i     = o_i_q;
  assign bus.o_q     = o_q_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_busy  = (state_q != StIdle);

endmodule
